// File: rtl/wb_stage.sv
// Write-back stage: commits register-file, CSR and TLB writes, and raises
// exceptions/ertn as a same-cycle pipeline flush.
module wb_stage #(
   parameter int CNT_W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         MEM_to_WB_valid,
   input  logic [216:0] MEM_to_WB_bus,
   output logic         WB_allowin,
   output logic         out_WB_valid,
   output logic         rf_we,
   output logic [4:0]   rf_waddr,
   output logic [31:0]  rf_wdata,
   output logic [13:0]  csr_num,
   input  logic [31:0]  csr_rvalue,
   output logic         csr_we,
   output logic [31:0]  csr_wmask,
   output logic [31:0]  csr_wvalue,
   output logic         wb_ex,
   output logic [5:0]   wb_ecode,
   output logic [8:0]   wb_esubcode,
   output logic [31:0]  wb_pc,
   output logic [31:0]  wb_vaddr,
   output logic         ertn_flush,
   output logic         exec_flush,
   output logic         tlbsrch_we,
   output logic         tlbrd_we,
   output logic         tlbwr_we,
   output logic         tlbfill_we,
   output logic         tlbsrch_hit,
   output logic [3:0]   tlbsrch_index,
   output logic [31:0]  debug_wb_pc,
   output logic [3:0]   debug_wb_rf_we,
   output logic [4:0]   debug_wb_rf_wnum,
   output logic [31:0]  debug_wb_rf_wdata
);

   typedef struct packed {
      logic        tlbsrch;
      logic        hit;
      logic [3:0]  index;
      logic        tlbrd;
      logic        tlbwr;
      logic        tlbfill;
      logic        invtlb;
      logic        adef;
      logic        ine;
      logic        ale;
      logic [31:0] ex_baddr;
      logic        brk;
      logic        rdcntid;
      logic        rdcntvl;
      logic        rdcntvh;
      logic [14:0] ex_code;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        syscall;
      logic        ertn;
      logic        csrrd;
      logic        csrwr;
      logic        csrxchg;
      logic [13:0] csr_num;
      logic [31:0] pc;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
   } wb_bus_t;

   wb_bus_t          r_bus;
   logic             r_valid;
   logic [CNT_W-1:0] r_cnt;

   logic        w_ready_go;
   logic        w_ex_any;
   logic        w_commit;
   logic [63:0] w_cnt_ext;
   logic        w_unused_ok;

   assign w_ready_go   = 1'b1;
   assign WB_allowin   = ~r_valid | w_ready_go;
   assign out_WB_valid = r_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_valid <= 1'b0;
      else if (exec_flush) r_valid <= 1'b0;
      else                 r_valid <= MEM_to_WB_valid;
   end

   // NOTE: the payload register is deliberately not reset; r_valid qualifies every use of it.
   always_ff @(posedge clk) begin
      if (MEM_to_WB_valid && WB_allowin && !exec_flush) r_bus <= wb_bus_t'(MEM_to_WB_bus);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_cnt <= '0;
      else        r_cnt <= r_cnt + CNT_W'(1);
   end

   assign w_cnt_ext   = 64'(r_cnt);
   assign w_unused_ok = ^{r_bus.ex_code, r_bus.invtlb};

   assign w_ex_any    = r_valid & (r_bus.adef | r_bus.ine | r_bus.syscall | r_bus.brk | r_bus.ale);
   assign w_commit    = r_valid & ~w_ex_any;
   assign wb_ex       = w_ex_any;
   assign wb_esubcode = 9'h000;
   assign wb_pc       = r_bus.pc;
   assign wb_vaddr    = (r_bus.adef | r_bus.ale) ? r_bus.ex_baddr : 32'h0;
   assign ertn_flush  = w_commit & r_bus.ertn;
   assign exec_flush  = wb_ex | ertn_flush;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      wb_ecode = 6'h00;
      if (w_ex_any) begin
         if (r_bus.adef)         wb_ecode = 6'h08;
         else if (r_bus.ine)     wb_ecode = 6'h0D;
         else if (r_bus.syscall) wb_ecode = 6'h0B;
         else if (r_bus.brk)     wb_ecode = 6'h0C;
         else                    wb_ecode = 6'h09;
      end
   end

   always_comb begin
      rf_wdata = r_bus.result;
      if (r_bus.csrrd | r_bus.csrwr | r_bus.csrxchg | r_bus.rdcntid) rf_wdata = csr_rvalue;
      else if (r_bus.rdcntvl)                                      rf_wdata = w_cnt_ext[31:0];
      else if (r_bus.rdcntvh)                                      rf_wdata = w_cnt_ext[63:32];
   end

   assign rf_we    = w_commit & r_bus.gr_we;
   assign rf_waddr = r_bus.dest;

   // rdcntid reads the TID CSR through the normal CSR read port.
   assign csr_num    = r_bus.rdcntid ? 14'h040 : r_bus.csr_num;
   assign csr_we     = w_commit & (r_bus.csrwr | r_bus.csrxchg);
   assign csr_wmask  = r_bus.csrxchg ? r_bus.rj : 32'hFFFF_FFFF;
   assign csr_wvalue = r_bus.rkd;

   assign tlbsrch_we    = w_commit & r_bus.tlbsrch;
   assign tlbrd_we      = w_commit & r_bus.tlbrd;
   assign tlbwr_we      = w_commit & r_bus.tlbwr;
   assign tlbfill_we    = w_commit & r_bus.tlbfill;
   assign tlbsrch_hit   = r_bus.hit;
   assign tlbsrch_index = r_bus.index;

   assign debug_wb_pc       = r_bus.pc;
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = r_bus.dest;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: CNT_W, 64, width of the stable counter read by rdcntvl.w/rdcntvh.w.
REQ-002 SHALL have ports (name direction width meaning), in this order:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset (asserted when 0)
  MEM_to_WB_valid  in  1  upstream stage holds a valid instruction
  MEM_to_WB_bus  in  217  instruction payload from the memory stage
  WB_allowin  out  1  stage can accept an instruction this cycle
  out_WB_valid  out  1  WB_valid register, for hazard detection
  rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port
  csr_num  out  14  CSR read/write address
  csr_rvalue  in  32  combinational CSR read data
  csr_we / csr_wmask / csr_wvalue  out  1/32/32  CSR write port
  wb_ex / wb_ecode / wb_esubcode  out  1/6/9  exception commit
  wb_pc / wb_vaddr  out  32/32  exception PC and bad address
  ertn_flush  out  1  ertn commit
  exec_flush  out  1  pipeline flush (wb_ex | ertn_flush)
  tlbsrch_we / tlbrd_we / tlbwr_we / tlbfill_we  out  1 each  TLB command commit pulses
  tlbsrch_hit / tlbsrch_index  out  1/4  tlbsrch result
  debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  trace
REQ-003 SHALL decode the bus as follows; ex_code and invtlb are carried but unused:
  [216] tlbsrch; [215] hit; [214:211] index; [210] tlbrd; [209] tlbwr; [208] tlbfill; [207] invtlb
  [206] adef; [205] ine; [204] ale; [203:172] ex_baddr; [171] brk; [170] rdcntid; [169] rdcntvl; [168] rdcntvh
  [167:153] ex_code; [152:121] rj; [120:89] rkd; [88] syscall; [87] ertn; [86] csrrd; [85] csrwr; [84] csrxchg
  [83:70] csr_num; [69:38] pc; [37] gr_we; [36:32] dest; [31:0] result

Function
REQ-004 SHALL hold WB_ready_go=1 and WB_allowin=1 at all times.
REQ-005 SHALL update WB_valid each clock edge: exec_flush -> 0; otherwise WB_valid <= MEM_to_WB_valid.
REQ-006 SHALL latch the bus into a 217-bit register when MEM_to_WB_valid & WB_allowin & ~exec_flush, and SHALL hold it otherwise.
REQ-007 SHALL define ex_any = WB_valid & (adef|ine|syscall|brk|ale) and drive wb_ex = ex_any.
REQ-008 SHALL select wb_ecode by priority: adef 0x08 > ine 0x0D > syscall 0x0B > brk 0x0C > ale 0x09; wb_ecode=0 when ~wb_ex.
REQ-009 SHALL drive wb_esubcode=0, wb_pc=pc, and wb_vaddr=ex_baddr when adef or ale, else 0.
REQ-010 SHALL drive ertn_flush = WB_valid & ertn & ~ex_any and exec_flush = wb_ex | ertn_flush, combinationally in the same cycle.
REQ-011 SHALL drive rf_we = WB_valid & gr_we & ~ex_any and rf_waddr = dest.
REQ-012 SHALL select rf_wdata by priority:
  - csrrd|csrwr|csrxchg|rdcntid -> csr_rvalue
  - rdcntvl -> cnt[31:0]
  - rdcntvh -> cnt[63:32]
  - otherwise -> result
REQ-013 SHALL drive csr_num = 14'h040 (TID) when rdcntid, else the bus csr_num.
REQ-014 SHALL drive csr_we = WB_valid & (csrwr|csrxchg) & ~ex_any, csr_wmask = csrxchg ? rj : 32'hFFFFFFFF, and csr_wvalue = rkd.
REQ-015 SHALL drive each tlb*_we = WB_valid & the corresponding inst & ~ex_any, and pass tlbsrch_hit/index through from the bus.
REQ-016 SHALL keep a CNT_W-bit counter cnt that increments every cycle, wraps from all-ones to 0, and is independent of valid and flush.
REQ-017 SHALL drive debug_wb_pc=pc, debug_wb_rf_we={4{rf_we}}, debug_wb_rf_wnum=dest, debug_wb_rf_wdata=rf_wdata.
REQ-018 SHALL, when an instruction arrives while exec_flush=1, discard it; WB_valid is 0 in the next cycle.
REQ-019 SHALL, when WB_valid=0, hold all write enables, wb_ex, ertn_flush and exec_flush at 0.

Reset
REQ-020 SHALL, on reset=0, immediately (asynchronously) clear WB_valid and cnt to 0, forcing every enable and flush output to 0; the bus register is not reset.
REQ-021 SHALL resume normal capture on the first rising edge after reset returns to 1; reset asserted mid-operation drops the in-flight instruction.

Verification
REQ-022 add.w, gr_we=1, dest=5, result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_we=4'hF.
REQ-023 syscall with gr_we=1 -> wb_ex=1, wb_ecode=0x0B, rf_we=0, exec_flush=1; following cycle WB_valid=0 even though MEM_to_WB_valid=1.
REQ-024 adef+ale together with ex_baddr=0x1C000003 -> wb_ecode=0x08, wb_vaddr=0x1C000003.
REQ-025 csrxchg with rj=0x0000FF00, rkd=0x12345678, csr_rvalue=0xAAAA5555 -> csr_we=1, csr_wmask=0x0000FF00, csr_wvalue=0x12345678, rf_wdata=0xAAAA5555.
REQ-026 preload cnt=0xFFFFFFFF_FFFFFFFE; rdcntvh then rdcntvl on successive cycles -> 0xFFFFFFFF then 0x00000000 (cnt wrapped).
REQ-027 reset=0 pulsed while WB_valid=1 with tlbwr -> tlbwr_we falls to 0 immediately, without waiting for a clock edge.
